// File: rtl/router_pkt_source.sv
// router_pkt_source: buffers a commanded payload, then sends header, payload and parity to the router input (cmd_*, pl_*, busy in; data_out, pkt_valid, tx_done out)
module router_pkt_source #(
  parameter int GAP_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  output logic       cmd_err,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  output logic       pl_ready,
  input  logic       busy,
  output logic [7:0] data_out,
  output logic       pkt_valid,
  output logic       tx_done
);
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP} state_t;
  state_t state_q, state_d;
  logic [1:0] addr_q, addr_d;
  logic [5:0] len_q, len_d, idx_q, idx_d;
  logic [7:0] par_q, par_d;
  logic [3:0] gap_q, gap_d;
  logic err_q, err_d;
  logic [7:0] mem_q [64];
  logic cmd_acc, pl_acc, xfer, last;
  assign cmd_acc = cmd_valid && state_q == IDLE;
  assign pl_acc = pl_valid && state_q == LOAD;
  assign xfer = !busy && (state_q == HEADER || state_q == PAYLOAD || state_q == PARITY);
  assign last = idx_q == len_q - 6'd1;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    len_d = len_q;
    idx_d = idx_q;
    par_d = par_q;
    gap_d = gap_q;
    err_d = cmd_acc && (cmd_addr == 2'd3 || cmd_len == 6'd0);
    case (state_q)
      IDLE: if (cmd_acc && !err_d) begin
        state_d = LOAD;
        addr_d = cmd_addr;
        len_d = cmd_len;
        par_d = {cmd_len, cmd_addr};
        idx_d = '0;
      end
      LOAD: if (pl_acc) begin
        par_d = par_q ^ pl_data;
        idx_d = last ? 6'd0 : idx_q + 6'd1;
        state_d = last ? HEADER : LOAD;
      end
      HEADER: if (xfer) state_d = PAYLOAD;
      PAYLOAD: if (xfer) begin
        idx_d = last ? idx_q : idx_q + 6'd1;
        state_d = last ? PARITY : PAYLOAD;
      end
      PARITY: if (xfer) begin
        state_d = GAP;
        gap_d = '0;
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        state_d = gap_q == 4'(GAP_CYCLES - 1) ? IDLE : GAP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      len_q <= '0;
      idx_q <= '0;
      par_q <= '0;
      gap_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      len_q <= len_d;
      idx_q <= idx_d;
      par_q <= par_d;
      gap_q <= gap_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) if (pl_acc) mem_q[idx_q] <= pl_data;
  assign cmd_ready = state_q == IDLE;
  assign pl_ready = state_q == LOAD;
  assign cmd_err = err_q;
  assign pkt_valid = state_q == HEADER || state_q == PAYLOAD;
  assign tx_done = state_q == GAP && gap_q == 4'd0;
  assign data_out = state_q == HEADER ? {len_q, addr_q} :
                    state_q == PAYLOAD ? mem_q[idx_q] :
                    state_q == PARITY ? par_q : 8'h00;
endmodule

// File: tb/tb_router_pkt_source.sv
// tb_router_pkt_source: randomized packets checked every cycle against a queue-based packet model plus literal spot checks
module tb_router_pkt_source;
  localparam int GAP = 2;
  logic clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, busy = 1'b0, pl_valid = 1'b0;
  logic [1:0] cmd_addr = '0;
  logic [5:0] cmd_len = '0;
  logic [7:0] pl_data = '0;
  logic cmd_ready, cmd_err, pl_ready, pkt_valid, tx_done;
  logic [7:0] data_out;
  int tests = 0, fails = 0;
  bit chk_en = 1'b0, rnd_busy = 1'b0;
  logic [7:0] pl[$];

  router_pkt_source #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_err(cmd_err),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready), .busy(busy),
    .data_out(data_out), .pkt_valid(pkt_valid), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk1(string n, logic a, logic e);
    tests++;
    if (a !== e) begin
      fails++;
      if (fails < 60) $display("FAIL %s: got %0b expected %0b at %0t", n, a, e, $time);
    end
  endtask

  task automatic chk8(string n, logic [7:0] a, logic [7:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      if (fails < 60) $display("FAIL %s: got %02h expected %02h at %0t", n, a, e, $time);
    end
  endtask

  // Model: mode 0 idle, 1 collecting payload, 2 sending pkt[] (header..parity), 3 gap
  int mode = 0, pos = 0, need = 0, gap_left = 0;
  bit err_pend = 1'b0;
  logic [7:0] pkt[$];

  function automatic logic [7:0] xor_all(input logic [7:0] q[$]);
    logic [7:0] p = 8'h00;
    foreach (q[i]) p ^= q[i];
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mode = 0;
      pkt.delete();
      err_pend = 1'b0;
    end else begin
      err_pend = 1'b0;
      if (mode == 0 && cmd_valid) begin
        if (cmd_addr == 2'd3 || cmd_len == 6'd0) err_pend = 1'b1;
        else begin
          pkt.delete();
          pkt.push_back({cmd_len, cmd_addr});
          need = int'(cmd_len);
          mode = 1;
        end
      end else if (mode == 1 && pl_valid) begin
        pkt.push_back(pl_data);
        need--;
        if (need == 0) begin
          pkt.push_back(xor_all(pkt));
          pos = 0;
          mode = 2;
        end
      end else if (mode == 2 && !busy) begin
        if (pos == pkt.size() - 1) begin
          mode = 3;
          gap_left = GAP;
        end else pos++;
      end else if (mode == 3) begin
        gap_left--;
        if (gap_left == 0) mode = 0;
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk1("cmd_ready", cmd_ready, mode == 0);
    chk1("pl_ready", pl_ready, mode == 1);
    chk1("cmd_err", cmd_err, err_pend);
    chk1("pkt_valid", pkt_valid, mode == 2 && pos < pkt.size() - 1);
    chk1("tx_done", tx_done, mode == 3 && gap_left == GAP);
    chk8("data_out", data_out, mode == 2 ? pkt[pos] : 8'h00);
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_busy) busy = 1'($urandom_range(0, 1));
  endtask

  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l);
    cmd_valid = 1'b1;
    cmd_addr = a;
    cmd_len = l;
    step();
    cmd_valid = 1'b0;
    cmd_addr = 2'($urandom);
    cmd_len = 6'($urandom);
  endtask

  task automatic fill_rand(input int l);
    pl.delete();
    repeat (l) pl.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] par_of(input logic [1:0] a, input logic [5:0] l);
    logic [7:0] p = {l, a};
    foreach (pl[i]) p ^= pl[i];
    return p;
  endfunction

  task automatic load(input bit gaps);
    foreach (pl[i]) begin
      if (gaps) while ($urandom_range(0, 2) == 0) begin
        pl_valid = 1'b0;
        pl_data = 8'($urandom);
        step();
      end
      pl_valid = 1'b1;
      pl_data = pl[i];
      step();
    end
    pl_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 1000) begin
      step();
      n++;
    end
    chk1("idle_reached", cmd_ready, 1'b1);
  endtask

  task automatic wait_done(input logic [7:0] p);
    int n = 0;
    bit prev, seen = 1'b0;
    while (!tx_done && n < 1000) begin
      prev = pkt_valid;
      step();
      n++;
      if (prev && !pkt_valid && !seen) begin
        seen = 1'b1;
        chk8("parity_byte", data_out, p);
      end
    end
    chk1("tx_done_seen", tx_done, 1'b1);
    chk1("parity_seen", seen, 1'b1);
    rnd_busy = 1'b0;
    busy = 1'b0;
    wait_idle();
  endtask

  initial begin
    int n, cnt;
    logic [1:0] a;
    logic [5:0] l;
    logic [7:0] p;
    step();
    step();
    chk_en = 1'b1;
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_pkt_valid", pkt_valid, 1'b0);
    chk8("rst_data_out", data_out, 8'h00);
    chk1("rst_pl_ready", pl_ready, 1'b0);
    rst = 1'b0;
    step();
    // basic packet
    pl = '{8'h11, 8'h22, 8'h33};
    send_cmd(2'd1, 6'd3);
    chk1("load_pl_ready", pl_ready, 1'b1);
    load(1'b0);
    chk8("basic_hdr", data_out, 8'h0D);
    chk1("basic_hdr_v", pkt_valid, 1'b1);
    step();
    chk8("basic_p0", data_out, 8'h11);
    step();
    chk8("basic_p1", data_out, 8'h22);
    step();
    chk8("basic_p2", data_out, 8'h33);
    chk1("basic_p2_v", pkt_valid, 1'b1);
    step();
    chk8("basic_par", data_out, 8'h0D);
    chk1("basic_par_v", pkt_valid, 1'b0);
    step();
    chk1("basic_tx_done", tx_done, 1'b1);
    chk1("basic_gap_ready", cmd_ready, 1'b0);
    step();
    chk1("basic_tx_done_off", tx_done, 1'b0);
    chk1("basic_gap2_ready", cmd_ready, 1'b0);
    step();
    chk1("basic_ready_back", cmd_ready, 1'b1);
    // header stall
    send_cmd(2'd1, 6'd3);
    load(1'b0);
    busy = 1'b1;
    chk8("hs_hdr", data_out, 8'h0D);
    repeat (3) begin
      step();
      chk8("hs_hold", data_out, 8'h0D);
      chk1("hs_hold_v", pkt_valid, 1'b1);
    end
    busy = 1'b0;
    step();
    chk8("hs_p0", data_out, 8'h11);
    wait_done(8'h0D);
    // illegal commands
    send_cmd(2'd3, 6'd5);
    chk1("ill_addr_err", cmd_err, 1'b1);
    chk1("ill_addr_pl_ready", pl_ready, 1'b0);
    chk1("ill_addr_pkt_valid", pkt_valid, 1'b0);
    step();
    chk1("ill_addr_err_off", cmd_err, 1'b0);
    send_cmd(2'd0, 6'd0);
    chk1("ill_len_err", cmd_err, 1'b1);
    chk1("ill_len_pl_ready", pl_ready, 1'b0);
    step();
    chk1("ill_len_err_off", cmd_err, 1'b0);
    chk1("ill_len_pkt_valid", pkt_valid, 1'b0);
    // max length with gaps and random busy
    fill_rand(63);
    send_cmd(2'd2, 6'd63);
    load(1'b1);
    chk8("max_hdr", data_out, 8'hFE);
    rnd_busy = 1'b1;
    wait_done(par_of(2'd2, 6'd63));
    // reset mid-payload
    fill_rand(4);
    send_cmd(2'd0, 6'd4);
    load(1'b0);
    step();
    step();
    chk8("rm_p1", data_out, pl[1]);
    rst = 1'b1;
    step();
    chk1("rm_pkt_valid", pkt_valid, 1'b0);
    chk8("rm_data_out", data_out, 8'h00);
    chk1("rm_cmd_ready", cmd_ready, 1'b1);
    rst = 1'b0;
    fill_rand(5);
    send_cmd(2'd2, 6'd5);
    load(1'b0);
    wait_done(par_of(2'd2, 6'd5));
    // parity stall
    fill_rand(2);
    p = par_of(2'd0, 6'd2);
    send_cmd(2'd0, 6'd2);
    load(1'b0);
    n = 0;
    while (pkt_valid && n < 100) begin
      step();
      n++;
    end
    busy = 1'b1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) busy = 1'b0;
      chk8("ps_par", data_out, p);
      chk1("ps_par_v", pkt_valid, 1'b0);
      if (tx_done) cnt++;
      step();
    end
    repeat (3) begin
      if (tx_done) cnt++;
      step();
    end
    chk8("ps_tx_done_count", 8'(cnt), 8'd1);
    wait_idle();
    // random traffic
    repeat (25) begin
      a = 2'($urandom_range(0, 3));
      l = 6'($urandom_range(0, 63));
      if (a == 2'd3 || l == 6'd0) begin
        send_cmd(a, l);
        chk1("rnd_cmd_err", cmd_err, 1'b1);
        step();
      end else begin
        fill_rand(int'(l));
        send_cmd(a, l);
        load(1'($urandom_range(0, 1)));
        rnd_busy = 1'b1;
        wait_done(par_of(a, l));
      end
    end
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
